// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: line/address/select widths, arbiter
// state encoding and the requester identity used for round-robin fairness.
package mem_arbiter_pkg;

   localparam int LC3B_LINE_W = 128;
   localparam int LC3B_ADDR_W = 12;
   localparam int LC3B_SEL_W  = 16;
   localparam int LC3B_CNT_W  = 16;

   typedef logic [LC3B_LINE_W-1:0] lc3b_line;
   typedef logic [LC3B_ADDR_W-1:0] lc3b_wb_adr;
   typedef logic [LC3B_SEL_W-1:0]  lc3b_word;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      DONE_I = 3'd3,
      DONE_D = 3'd4
   } lc3b_arb_state;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } lc3b_arb_side;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter: holds at all-ones once reached; cleared by the
// asynchronous active-low reset.
module mem_arbiter_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between instruction
// fetch and data memory; every output comes straight from a flop.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LINE_W = LC3B_LINE_W,
   parameter int ADDR_W = LC3B_ADDR_W,
   parameter int SEL_W  = LC3B_SEL_W,
   parameter int CNT_W  = LC3B_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifetch_read,
   input  logic [ADDR_W-1:0] ifetch_address,
   output logic [LINE_W-1:0] ifetch_rdata,
   output logic              ifetch_resp,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [LINE_W-1:0] mem_wdata,
   input  logic [SEL_W-1:0]  mem_sel,
   output logic [LINE_W-1:0] mem_rdata,
   output logic              mem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   output logic [SEL_W-1:0]  pmem_sel,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic [CNT_W-1:0]  i_grant_cnt,
   output logic [CNT_W-1:0]  d_grant_cnt,
   output logic [2:0]        dbg_state
);

   lc3b_arb_state     state_q, state_d;
   lc3b_arb_side      last_grant_q, last_grant_d;
   logic              pmem_read_q, pmem_read_d;
   logic              pmem_write_q, pmem_write_d;
   logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
   logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
   logic [SEL_W-1:0]  pmem_sel_q, pmem_sel_d;
   logic [LINE_W-1:0] rdata_q, rdata_d;
   logic              ifetch_resp_q, ifetch_resp_d;
   logic              mem_resp_q, mem_resp_d;
   logic              i_inc, d_inc;
   logic              i_req, d_req;

   assign i_req = ifetch_read;
   assign d_req = mem_read | mem_write;

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      pmem_sel_d     = pmem_sel_q;
      rdata_d        = rdata_q;
      ifetch_resp_d  = 1'b0;
      mem_resp_d     = 1'b0;
      i_inc          = 1'b0;
      d_inc          = 1'b0;
      case (state_q)
         IDLE: begin
            // Under contention the side not granted last wins.
            if (d_req && (!i_req || (last_grant_q == SIDE_I))) begin
               state_d        = BUSY_D;
               last_grant_d   = SIDE_D;
               d_inc          = 1'b1;
               pmem_read_d    = !mem_write;
               pmem_write_d   = mem_write;
               pmem_address_d = mem_address;
               pmem_wdata_d   = mem_wdata;
               pmem_sel_d     = mem_sel;
            end else if (i_req) begin
               state_d        = BUSY_I;
               last_grant_d   = SIDE_I;
               i_inc          = 1'b1;
               pmem_read_d    = 1'b1;
               pmem_write_d   = 1'b0;
               pmem_address_d = ifetch_address;
            end
         end
         BUSY_I: begin
            if (pmem_resp) begin
               state_d       = DONE_I;
               pmem_read_d   = 1'b0;
               pmem_write_d  = 1'b0;
               rdata_d       = pmem_rdata;
               ifetch_resp_d = 1'b1;
            end
         end
         BUSY_D: begin
            if (pmem_resp) begin
               state_d      = DONE_D;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               rdata_d      = pmem_rdata;
               mem_resp_d   = 1'b1;
            end
         end
         DONE_I, DONE_D: state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         last_grant_q   <= SIDE_I;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         pmem_sel_q     <= '0;
         rdata_q        <= '0;
         ifetch_resp_q  <= 1'b0;
         mem_resp_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
         pmem_sel_q     <= pmem_sel_d;
         rdata_q        <= rdata_d;
         ifetch_resp_q  <= ifetch_resp_d;
         mem_resp_q     <= mem_resp_d;
      end
   end

   mem_arbiter_sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (i_inc),
      .cnt   (i_grant_cnt)
   );

   mem_arbiter_sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (d_inc),
      .cnt   (d_grant_cnt)
   );

   // Both sides see the same response line; only the pulsed side cares.
   assign ifetch_rdata = rdata_q;
   assign mem_rdata    = rdata_q;
   assign ifetch_resp  = ifetch_resp_q;
   assign mem_resp     = mem_resp_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;
   assign pmem_sel     = pmem_sel_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone fetch, contention ordering,
// write capture, mid-transaction reset and counter saturation (CNT_W=2).
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 12;
   localparam int SEL_W  = 16;
   localparam int CNT_W  = 2;

   logic              clk;
   logic              rst_n;
   logic              ifetch_read;
   logic [ADDR_W-1:0] ifetch_address;
   logic [LINE_W-1:0] ifetch_rdata;
   logic              ifetch_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [SEL_W-1:0]  mem_sel;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [SEL_W-1:0]  pmem_sel;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;
   logic [CNT_W-1:0]  i_grant_cnt;
   logic [CNT_W-1:0]  d_grant_cnt;
   logic [2:0]        dbg_state;

   int tests_run;
   int tests_failed;

   mem_arbiter #(
      .LINE_W (LINE_W),
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifetch_read    (ifetch_read),
      .ifetch_address (ifetch_address),
      .ifetch_rdata   (ifetch_rdata),
      .ifetch_resp    (ifetch_resp),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_sel        (mem_sel),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_sel       (pmem_sel),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp),
      .i_grant_cnt    (i_grant_cnt),
      .d_grant_cnt    (d_grant_cnt),
      .dbg_state      (dbg_state)
   );

   // clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Downstream memory reply: wait, then one-cycle pmem_resp with data.
   task automatic pmem_reply(input int wait_cycles, input logic [LINE_W-1:0] data);
      repeat (wait_cycles) tick();
      pmem_resp  = 1'b1;
      pmem_rdata = data;
      tick();
      pmem_resp  = 1'b0;
   endtask

   initial begin
      logic [LINE_W-1:0] pat_a5;
      logic [LINE_W-1:0] wpat;
      logic [CNT_W-1:0]  exp_i;
      logic [CNT_W-1:0]  exp_d;
      logic              exp_side_d;
      tests_run      = 0;
      tests_failed   = 0;
      pat_a5         = {16{8'hA5}};
      wpat           = {8{16'h1234}};
      rst_n          = 1'b0;
      ifetch_read    = 1'b0;
      ifetch_address = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_wdata      = '0;
      mem_sel        = '0;
      pmem_rdata     = '0;
      pmem_resp      = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_state", 128'(dbg_state), 128'(IDLE));
      chk("rst_pmem_read", 128'(pmem_read), 128'd0);
      chk("rst_pmem_write", 128'(pmem_write), 128'd0);
      chk("rst_pmem_addr", 128'(pmem_address), 128'd0);
      chk("rst_resp", 128'({ifetch_resp, mem_resp}), 128'd0);
      chk("rst_rdata", mem_rdata, 128'd0);
      chk("rst_cnts", 128'({i_grant_cnt, d_grant_cnt}), 128'd0);
      rst_n = 1'b1;
      tick();

      // Lone I read, reply three cycles after pmem_read appears
      ifetch_read    = 1'b1;
      ifetch_address = 12'h040;
      tick();
      chk("i_pmem_read", 128'(pmem_read), 128'd1);
      chk("i_pmem_write", 128'(pmem_write), 128'd0);
      chk("i_pmem_addr", 128'(pmem_address), 128'h040);
      chk("i_cnt1", 128'(i_grant_cnt), 128'd1);
      chk("i_no_resp_early", 128'(ifetch_resp), 128'd0);
      pmem_reply(2, pat_a5);
      chk("i_resp", 128'(ifetch_resp), 128'd1);
      chk("i_rdata", ifetch_rdata, pat_a5);
      chk("i_pmem_read_drop", 128'(pmem_read), 128'd0);
      ifetch_read = 1'b0;
      tick();
      chk("i_resp_pulse", 128'(ifetch_resp), 128'd0);
      chk("i_back_idle", 128'(dbg_state), 128'(IDLE));

      // Contention right after reset: D first, then I
      rst_n = 1'b0;
      tick();
      rst_n          = 1'b1;
      ifetch_read    = 1'b1;
      ifetch_address = 12'h100;
      mem_read       = 1'b1;
      mem_address    = 12'h200;
      tick();
      chk("c_first_d", 128'(dbg_state), 128'(BUSY_D));
      chk("c_addr_d", 128'(pmem_address), 128'h200);
      chk("c_cnts_a", 128'({i_grant_cnt, d_grant_cnt}), 128'({2'd0, 2'd1}));
      pmem_reply(0, 128'hD0D0);
      chk("c_mem_resp", 128'({ifetch_resp, mem_resp}), 128'b01);
      chk("c_mem_rdata", mem_rdata, 128'hD0D0);
      mem_read = 1'b0;
      tick();
      chk("c_gap_idle", 128'(dbg_state), 128'(IDLE));
      tick();
      chk("c_then_i", 128'(dbg_state), 128'(BUSY_I));
      chk("c_addr_i", 128'(pmem_address), 128'h100);
      chk("c_cnts_b", 128'({i_grant_cnt, d_grant_cnt}), 128'({2'd1, 2'd1}));
      pmem_reply(0, 128'hC0C0);
      chk("c_i_resp", 128'({ifetch_resp, mem_resp}), 128'b10);
      tick();

      // Sustained contention: six grants alternate D,I,D,I,D,I
      mem_read   = 1'b1;
      exp_i      = 2'd1;
      exp_d      = 2'd1;
      exp_side_d = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         chk($sformatf("s_grant%0d", n), 128'(dbg_state),
             exp_side_d ? 128'(BUSY_D) : 128'(BUSY_I));
         chk($sformatf("s_addr%0d", n), 128'(pmem_address),
             exp_side_d ? 128'h200 : 128'h100);
         if (exp_side_d) begin
            if (exp_d != 2'b11) exp_d = exp_d + 2'd1;
         end else begin
            if (exp_i != 2'b11) exp_i = exp_i + 2'd1;
         end
         pmem_reply(1, 128'(n));
         chk($sformatf("s_resp%0d", n), 128'({ifetch_resp, mem_resp}),
             exp_side_d ? 128'b01 : 128'b10);
         tick();
         chk($sformatf("s_idle%0d", n), 128'(dbg_state), 128'(IDLE));
         exp_side_d = !exp_side_d;
      end
      chk("s_cnts", 128'({i_grant_cnt, d_grant_cnt}), 128'({exp_i, exp_d}));

      // Write with read also high; address/sel change while busy is ignored
      ifetch_read = 1'b0;
      mem_read    = 1'b1;
      mem_write   = 1'b1;
      mem_address = 12'h3C0;
      mem_wdata   = wpat;
      mem_sel     = 16'h0003;
      tick();
      chk("w_state", 128'(dbg_state), 128'(BUSY_D));
      chk("w_ops", 128'({pmem_read, pmem_write}), 128'b01);
      chk("w_wdata", pmem_wdata, wpat);
      chk("w_sel", 128'(pmem_sel), 128'h0003);
      mem_address = 12'hFFF;
      mem_sel     = 16'hFFFF;
      mem_wdata   = '0;
      tick();
      chk("w_addr_held", 128'(pmem_address), 128'h3C0);
      chk("w_sel_held", 128'(pmem_sel), 128'h0003);
      chk("w_wdata_held", pmem_wdata, wpat);
      pmem_reply(0, '0);
      chk("w_resp", 128'({ifetch_resp, mem_resp, pmem_write}), 128'b010);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      tick();
      chk("w_resp_pulse", 128'(mem_resp), 128'd0);

      // Asynchronous reset in the middle of BUSY_D
      mem_write   = 1'b1;
      mem_address = 12'h055;
      tick();
      chk("r_busy", 128'({pmem_write, 3'(dbg_state)}), 128'({1'b1, 3'(BUSY_D)}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("r_write_drop", 128'(pmem_write), 128'd0);
      chk("r_addr_clr", 128'(pmem_address), 128'd0);
      chk("r_state", 128'(dbg_state), 128'(IDLE));
      chk("r_cnts", 128'({i_grant_cnt, d_grant_cnt}), 128'd0);
      mem_write = 1'b0;
      tick();
      rst_n     = 1'b1;
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      chk("r_stray_resp", 128'({ifetch_resp, mem_resp, pmem_read, pmem_write}), 128'd0);
      chk("r_stray_state", 128'(dbg_state), 128'(IDLE));

      // Counter saturation: five I grants with a 2-bit counter
      exp_i = 2'd0;
      for (int n = 0; n < 5; n++) begin
         ifetch_read = 1'b1;
         tick();
         if (exp_i != 2'b11) exp_i = exp_i + 2'd1;
         chk($sformatf("sat_cnt%0d", n), 128'(i_grant_cnt), 128'(exp_i));
         pmem_reply(0, '0);
         ifetch_read = 1'b0;
         tick();
      end
      chk("sat_final", 128'({i_grant_cnt, d_grant_cnt}), 128'({2'b11, 2'b00}));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
